if_id_skid_pipe: RTL and testbench
==================================

Name: if_id_skid_pipe

Overview:
Parametrised IF/ID pipeline stage register with a ready/valid handshake on both sides, a 2-entry skid buffer, synchronous flush with bubble insertion, and a saturating flush counter. It sits between instruction fetch and decode. It replaces the plain always-load stage register, so fetch can be back-pressured by decode stalls and squashed on taken branches without losing or duplicating instructions.

Parameters:
IW, 32, instruction width in bits
AW, 32, next-PC width in bits
NOP_INSTR, 32'h0000_0000, instruction value driven on out_instr when no valid entry is held (IW bits)
CW, 8, width of flush_cnt

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents a beat
in_ready  output  1  stage can accept; registered, no combinational path from out_ready
in_instr  input  IW  fetched instruction
in_npc  input  AW  PC+4 of fetched instruction
flush  input  1  synchronous squash of all held and incoming beats
out_valid  output  1  decode-side beat valid
out_ready  input  1  decode accepts beat
out_instr  output  IW  instruction to decode
out_npc  output  AW  next-PC to decode
flush_cnt  output  CW  saturating count of beats discarded by flush

Behaviour:
- Reset (rst_n low, asynchronous): state=EMPTY, out_valid=0, out_instr=NOP_INSTR, out_npc=0, in_ready=1, skid entry cleared, flush_cnt=0. Reset mid-transfer drops all held beats; these drops are not counted.
- Accept = in_valid & in_ready. Take = out_valid & out_ready. Inputs are sampled only on accept.
- Latency: accepted beat appears on out_* the next cycle if the main register is free. Throughput is 1 beat/cycle while out_ready=1.
- Storage: main register (drives out_*) plus one skid entry. States:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE (main <= input).
  - ONE: out_valid=1, in_ready=1.
    - accept & take -> ONE (main <= input).
    - accept & !take -> FULL (skid <= input, in_ready=0 next cycle).
    - !accept & take -> EMPTY.
    - otherwise hold.
  - FULL: out_valid=1, in_ready=0.
    - take -> ONE (main <= skid, in_ready=1 next cycle).
    - otherwise hold.
- Stability: while out_valid=1 and out_ready=0, out_instr/out_npc do not change.
- Order is strictly FIFO: the skid entry is never presented ahead of the main entry.
- When the stage goes EMPTY via take, out_instr <= NOP_INSTR and out_npc <= 0.
- Flush (sampled at rising edge, priority over everything except reset):
  - Next state is EMPTY: out_valid=0, out_instr=NOP_INSTR, out_npc=0, in_ready=1.
  - A beat accepted in the flush cycle is discarded.
  - A take in the flush cycle completes normally. The consumer owns that beat and it is not counted.
- flush_cnt increments by the number of beats discarded in the flush cycle:
  - main entry if valid and not taken,
  - plus skid entry if valid,
  - plus the accepted input beat.
  - Range is 0..3 per flush. Saturates at 2^CW-1, never wraps. Cleared only by reset.
- flush held high for multiple cycles: the stage stays EMPTY. Every accepted beat is discarded and counted.
- Widths: flush_cnt addition is done at CW+2 bits, then clamped to 2^CW-1.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with FULL state -> immediately out_valid=0, out_instr=0, out_npc=0, in_ready=1, flush_cnt=0.
- Streaming: out_ready=1, beats instr=0x20080001..0x20080004 with npc=0x4..0x10 on consecutive cycles -> same values on out_* one cycle later, back-to-back, in_ready never drops.
- Back-pressure: stream 0xA1, 0xA2, 0xA3 with out_ready=0 from cycle 1 -> out holds 0xA1, skid holds 0xA2, in_ready=0 and 0xA3 held by source; out_ready=1 -> out 0xA1, 0xA2, 0xA3 in order, no loss or duplicate.
- Flush in FULL: state FULL (0xB1 main, 0xB2 skid), in_valid=1 but not accepted, flush=1, out_ready=0 -> next cycle EMPTY, out_instr=NOP_INSTR, flush_cnt=2.
- Flush with take and accept: state ONE (0xC1), out_ready=1, accept 0xC2, flush=1 -> 0xC1 consumed, 0xC2 dropped, flush_cnt +1, EMPTY.
- Saturation: CW=2, issue flushes discarding 3, then 2 beats -> flush_cnt=3 after first flush and stays 3.

Source files
------------

// File: rtl/if_id_skid_pipe.sv
// IF/ID pipeline stage with a ready/valid handshake on both sides.
// A main register drives decode and a single skid entry absorbs one beat
// when decode stalls. A synchronous flush squashes everything held or
// arriving, and a saturating counter records how many beats were discarded.
module if_id_skid_pipe #(
    parameter int unsigned     IW        = 32,
    parameter int unsigned     AW        = 32,
    parameter logic [IW-1:0]   NOP_INSTR = '0,
    parameter int unsigned     CW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [AW-1:0] in_npc,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_npc,
    output logic [CW-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] main_instr_q, main_instr_d;
    logic [AW-1:0] main_npc_q, main_npc_d;
    logic [IW-1:0] skid_instr_q, skid_instr_d;
    logic [AW-1:0] skid_npc_q, skid_npc_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    logic          accept;
    logic          take;
    logic          main_drop;
    logic          skid_drop;
    logic [CW+1:0] cnt_sum;

    // Handshake outputs decode the state register only, so in_ready has
    // no combinational dependency on out_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_instr = main_instr_q;
    assign out_npc   = main_npc_q;
    assign flush_cnt = flush_cnt_q;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    // Next-state, datapath and flush accounting.
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_npc_d   = main_npc_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;
        flush_cnt_d  = flush_cnt_q;
        main_drop    = out_valid & ~out_ready;
        skid_drop    = (state_q == FULL);
        cnt_sum      = {2'b00, flush_cnt_q} + (CW+2)'(main_drop)
                     + (CW+2)'(skid_drop) + (CW+2)'(accept);

        if (flush) begin
            state_d      = EMPTY;
            main_instr_d = NOP_INSTR;
            main_npc_d   = '0;
            skid_instr_d = '0;
            skid_npc_d   = '0;
            if (cnt_sum > {2'b00, {CW{1'b1}}}) begin
                flush_cnt_d = '1;
            end else begin
                flush_cnt_d = cnt_sum[CW-1:0];
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_instr_d = in_instr;
                        main_npc_d   = in_npc;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_instr_d = in_instr;
                        main_npc_d   = in_npc;
                    end else if (accept) begin
                        skid_instr_d = in_instr;
                        skid_npc_d   = in_npc;
                        state_d      = FULL;
                    end else if (take) begin
                        main_instr_d = NOP_INSTR;
                        main_npc_d   = '0;
                        state_d      = EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        main_instr_d = skid_instr_q;
                        main_npc_d   = skid_npc_q;
                        skid_instr_d = '0;
                        skid_npc_d   = '0;
                        state_d      = ONE;
                    end
                end
                default: begin
                    state_d      = EMPTY;
                    main_instr_d = NOP_INSTR;
                    main_npc_d   = '0;
                end
            endcase
        end
    end

    // State, storage and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            main_instr_q <= NOP_INSTR;
            main_npc_q   <= '0;
            skid_instr_q <= '0;
            skid_npc_q   <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_npc_q   <= main_npc_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid_pipe.sv
// Bench for if_id_skid_pipe: a queue-based model of the stage (at most two
// beats in FIFO order) is compared against two DUTs, CW=8 and CW=2, every
// cycle; directed sequences add literal expectations.
module tb_if_id_skid_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_npc;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [31:0] out_instr, out_instr2;
    logic [31:0] out_npc,   out_npc2;
    logic [7:0]  flush_cnt;
    logic [1:0]  flush_cnt2;

    int n_cmp;
    int n_bad;

    // behavioural model state
    logic [31:0] mq_i[$];
    logic [31:0] mq_n[$];
    int          m_cnt8;
    int          m_cnt2;

    if_id_skid_pipe #(.IW(32), .AW(32), .NOP_INSTR(32'h0000_0000), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_npc(in_npc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_npc(out_npc),
        .flush_cnt(flush_cnt)
    );

    if_id_skid_pipe #(.IW(32), .AW(32), .NOP_INSTR(32'h0000_0000), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_npc(in_npc),
        .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_instr(out_instr2), .out_npc(out_npc2),
        .flush_cnt(flush_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] ei, en;
        logic        ev;
        ev = (mq_i.size() > 0);
        ei = ev ? mq_i[0] : 32'h0;
        en = ev ? mq_n[0] : 32'h0;
        chk("out_valid",   32'(out_valid),  32'(ev));
        chk("in_ready",    32'(in_ready),   32'(mq_i.size() < 2));
        chk("out_instr",   out_instr,       ei);
        chk("out_npc",     out_npc,         en);
        chk("flush_cnt",   32'(flush_cnt),  32'(m_cnt8));
        chk("out_valid2",  32'(out_valid2), 32'(ev));
        chk("in_ready2",   32'(in_ready2),  32'(mq_i.size() < 2));
        chk("out_instr2",  out_instr2,      ei);
        chk("flush_cnt2",  32'(flush_cnt2), 32'(m_cnt2));
    endtask

    task automatic model_clear(input logic clr_cnt);
        mq_i.delete();
        mq_n.delete();
        if (clr_cnt) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end
    endtask

    // One cycle: drive at negedge, model updates at posedge, compare at next negedge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] np,
                        input logic fl, input logic ordy, output logic acc);
        int   sz;
        int   drop;
        logic tk;
        in_valid  = iv;
        in_instr  = ins;
        in_npc    = np;
        flush     = fl;
        out_ready = ordy;
        sz  = mq_i.size();
        tk  = (sz > 0) && ordy;
        acc = iv && (sz < 2);
        @(posedge clk);
        if (fl) begin
            drop   = sz - int'(tk) + int'(acc);
            m_cnt8 = (m_cnt8 + drop > 255) ? 255 : m_cnt8 + drop;
            m_cnt2 = (m_cnt2 + drop > 3)   ? 3   : m_cnt2 + drop;
            model_clear(1'b0);
        end else begin
            if (tk) begin
                void'(mq_i.pop_front());
                void'(mq_n.pop_front());
            end
            if (acc) begin
                mq_i.push_back(ins);
                mq_n.push_back(np);
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic ordy);
        logic a;
        step(1'b0, 32'h0, 32'h0, 1'b0, ordy, a);
    endtask

    initial begin
        logic        a;
        logic        pend;
        logic [31:0] p_i, p_n;
        int          c0;

        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_npc = '0;
        flush = 1'b0; out_ready = 1'b0;
        model_clear(1'b1);

        // reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        compare_all();

        // streaming, out_ready held high
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 32'h2008_0000 + 32'(i), 32'(4 * i), 1'b0, 1'b1, a);
            chk("stream_instr", out_instr, 32'h2008_0000 + 32'(i));
            chk("stream_npc",   out_npc,   32'(4 * i));
            chk("stream_ready", 32'(in_ready), 32'h1);
        end
        idle(1'b1);
        chk("stream_drained", 32'(out_valid), 32'h0);

        // back-pressure
        step(1'b1, 32'hA1, 32'h4, 1'b0, 1'b0, a);
        step(1'b1, 32'hA2, 32'h8, 1'b0, 1'b0, a);
        step(1'b1, 32'hA3, 32'hC, 1'b0, 1'b0, a);
        chk("bp_a3_refused", 32'(a), 32'h0);
        chk("bp_hold_a1",    out_instr, 32'hA1);
        chk("bp_in_ready",   32'(in_ready), 32'h0);
        step(1'b1, 32'hA3, 32'hC, 1'b0, 1'b1, a);
        chk("bp_out_a2", out_instr, 32'hA2);
        step(1'b1, 32'hA3, 32'hC, 1'b0, 1'b1, a);
        chk("bp_out_a3", out_instr, 32'hA3);
        idle(1'b1);
        chk("bp_empty_nop", out_instr, 32'h0);

        // flush while FULL, incoming beat not accepted
        step(1'b1, 32'hB1, 32'h4, 1'b0, 1'b0, a);
        step(1'b1, 32'hB2, 32'h8, 1'b0, 1'b0, a);
        step(1'b1, 32'hB3, 32'hC, 1'b1, 1'b0, a);
        chk("flfull_valid", 32'(out_valid), 32'h0);
        chk("flfull_instr", out_instr, 32'h0);
        chk("flfull_cnt",   32'(flush_cnt), 32'd2);
        chk("flfull_cnt2",  32'(flush_cnt2), 32'd2);

        // flush with take and accept
        step(1'b1, 32'hC1, 32'h4, 1'b0, 1'b0, a);
        step(1'b1, 32'hC2, 32'h8, 1'b1, 1'b1, a);
        chk("fltake_valid", 32'(out_valid), 32'h0);
        chk("fltake_cnt",   32'(flush_cnt), 32'd3);
        chk("fltake_cnt2",  32'(flush_cnt2), 32'd3);

        // CW=2 counter saturates
        step(1'b1, 32'hD1, 32'h4, 1'b0, 1'b0, a);
        step(1'b1, 32'hD2, 32'h8, 1'b0, 1'b0, a);
        step(1'b0, 32'h0,  32'h0, 1'b1, 1'b0, a);
        chk("sat_cnt",  32'(flush_cnt), 32'd5);
        chk("sat_cnt2", 32'(flush_cnt2), 32'd3);

        // flush held for several cycles: every accepted beat counted
        c0 = m_cnt8;
        for (int i = 0; i < 3; i++) step(1'b1, 32'hE0 + 32'(i), 32'h0, 1'b1, 1'b0, a);
        chk("multi_flush_cnt", 32'(flush_cnt), 32'(c0 + 3));
        flush = 1'b0;

        // asynchronous reset mid-cycle while FULL
        step(1'b1, 32'hF1, 32'h4, 1'b0, 1'b0, a);
        step(1'b1, 32'hF2, 32'h8, 1'b0, 1'b0, a);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_instr", out_instr, 32'h0);
        chk("arst_npc",   out_npc, 32'h0);
        chk("arst_ready", 32'(in_ready), 32'h1);
        chk("arst_cnt",   32'(flush_cnt), 32'h0);
        model_clear(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compare_all();

        // randomized traffic; source holds an unaccepted beat
        pend = 1'b0; p_i = '0; p_n = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend && ($urandom_range(0, 9) < 7)) begin
                pend = 1'b1;
                p_i  = $urandom;
                p_n  = $urandom;
            end
            step(pend, p_i, p_n, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6), a);
            if (a) pend = 1'b0;
        end
        chk("rand_cnt_sat", 32'(flush_cnt2), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
